trap_sequencer: RTL and testbench

- Write-back-stage controller that commits precise traps and trap returns.
- Consumes the exception packet carried down the pipeline, plus mret/sret flags. Freezes and flushes the pipeline, then sequences single-port CSR writes (epc, cause, tval, status).
- Finally issues a PC redirect and updates the current privilege level.
- Sits between the WB-stage exception register and the CSR file / IF-stage PC mux.

---
 rtl/trap_sequencer_pkg.sv | 57 +++++
 rtl/trap_status_calc.sv | 46 ++++
 rtl/trap_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_trap_sequencer.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_sequencer_pkg.sv
// Shared types and constants for the write-back trap sequencer.
// The package keeps the CsrPack name because the WB exception packet type lives here.
package CsrPack;

   localparam int CSR_XLEN = 64;

   typedef struct packed {
      logic                except;
      logic [CSR_XLEN-1:0] epc;
      logic [CSR_XLEN-1:0] ecause;
      logic [CSR_XLEN-1:0] etval;
   } ExceptPack;

   typedef enum logic [2:0] {
      IDLE,
      WR_EPC,
      WR_CAUSE,
      WR_TVAL,
      WR_STATUS,
      RET_STATUS,
      REDIRECT
   } trap_state_t;

   typedef enum logic [1:0] {
      OP_TRAP_M,
      OP_TRAP_S,
      OP_MRET,
      OP_SRET
   } status_op_t;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MTVAL   = 12'h343;
   localparam logic [11:0] CSR_SEPC    = 12'h141;
   localparam logic [11:0] CSR_SCAUSE  = 12'h142;
   localparam logic [11:0] CSR_STVAL   = 12'h143;

   localparam int MSTATUS_SIE    = 1;
   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_SPIE   = 5;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_SPP    = 8;
   localparam int MSTATUS_MPP_LO = 11;
   localparam int MSTATUS_MPP_HI = 12;

   localparam logic [1:0] PRIV_U = 2'b00;
   localparam logic [1:0] PRIV_S = 2'b01;
   localparam logic [1:0] PRIV_M = 2'b11;

   function automatic logic [11:0] trap_csr_addr(input logic       to_s,
                                                 input logic [11:0] m_addr,
                                                 input logic [11:0] s_addr);
      return to_s ? s_addr : m_addr;
   endfunction

endpackage

// File: rtl/trap_status_calc.sv
// Combinational mstatus image and resulting privilege for trap entry (M or S) and MRET/SRET.
module trap_status_calc
   import CsrPack::*;
#(
   parameter int XLEN = 64
) (
   input  status_op_t      op_i,
   input  logic [XLEN-1:0] mstatus_i,
   input  logic [1:0]      priv_i,
   output logic [XLEN-1:0] status_o,
   output logic [1:0]      new_priv_o
);

   always_comb begin
      status_o   = mstatus_i;
      new_priv_o = PRIV_M;
      case (op_i)
         OP_TRAP_M: begin
            status_o[MSTATUS_MPIE]                  = mstatus_i[MSTATUS_MIE];
            status_o[MSTATUS_MIE]                   = 1'b0;
            status_o[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = priv_i;
            new_priv_o                              = PRIV_M;
         end
         OP_TRAP_S: begin
            status_o[MSTATUS_SPIE] = mstatus_i[MSTATUS_SIE];
            status_o[MSTATUS_SIE]  = 1'b0;
            status_o[MSTATUS_SPP]  = priv_i[0];
            new_priv_o             = PRIV_S;
         end
         OP_MRET: begin
            status_o[MSTATUS_MIE]                   = mstatus_i[MSTATUS_MPIE];
            status_o[MSTATUS_MPIE]                  = 1'b1;
            status_o[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_U;
            new_priv_o = mstatus_i[MSTATUS_MPP_HI:MSTATUS_MPP_LO];
         end
         OP_SRET: begin
            status_o[MSTATUS_SIE]  = mstatus_i[MSTATUS_SPIE];
            status_o[MSTATUS_SPIE] = 1'b1;
            status_o[MSTATUS_SPP]  = 1'b0;
            new_priv_o             = {1'b0, mstatus_i[MSTATUS_SPP]};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/trap_sequencer.sv
// Write-back trap sequencer: commits traps and xRET as single-port CSR writes, then redirects the PC.
// Define TRAP_SEQ_INTR_EN to add the interrupt request path and vectored mtvec support.
module trap_sequencer
   import CsrPack::*;
#(
   parameter int         XLEN       = 64,
   parameter logic [1:0] RESET_PRIV = 2'b11
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            valid_wb,
   input  ExceptPack       except_wb,
   input  logic            mret_wb,
   input  logic            sret_wb,
   input  logic [XLEN-1:0] mstatus_i,
   input  logic [XLEN-1:0] medeleg_i,
   input  logic [XLEN-1:0] mtvec_i,
   input  logic [XLEN-1:0] stvec_i,
   input  logic [XLEN-1:0] mepc_i,
   input  logic [XLEN-1:0] sepc_i,
`ifdef TRAP_SEQ_INTR_EN
   input  logic            int_req_i,
   input  logic [XLEN-1:0] int_cause_i,
   input  logic [XLEN-1:0] pc_wb_i,
`endif
   output logic            csr_we_o,
   output logic [11:0]     csr_waddr_o,
   output logic [XLEN-1:0] csr_wdata_o,
   output logic            stall_o,
   output logic            flush_o,
   output logic            redirect_valid_o,
   output logic [XLEN-1:0] redirect_pc_o,
   output logic [1:0]      priv_o,
   output logic            busy_o
);

   localparam logic [XLEN-1:0] TVEC_BASE_MASK = {{(XLEN-2){1'b1}}, 2'b00};

   trap_state_t     state_q, state_d;
   status_op_t      op_q, op_d;
   logic [XLEN-1:0] epc_q, epc_d;
   logic [XLEN-1:0] cause_q, cause_d;
   logic [XLEN-1:0] tval_q, tval_d;
   logic [1:0]      trap_priv_q, trap_priv_d;
   logic [1:0]      new_priv_q, new_priv_d;
   logic [1:0]      priv_q, priv_d;
`ifdef TRAP_SEQ_INTR_EN
   logic            is_intr_q, is_intr_d;
   logic            take_int;
`endif
   logic            take_exc;
   logic            to_s;
   logic            trap_to_s;
   logic [XLEN-1:0] status_img;
   logic [1:0]      ret_priv;
   logic [XLEN-1:0] redirect_target;

   trap_status_calc #(.XLEN(XLEN)) u_status_calc (
      .op_i       (op_q),
      .mstatus_i  (mstatus_i),
      .priv_i     (trap_priv_q),
      .status_o   (status_img),
      .new_priv_o (ret_priv)
   );

   assign take_exc  = valid_wb & except_wb.except;
`ifdef TRAP_SEQ_INTR_EN
   assign take_int  = valid_wb & int_req_i & ~except_wb.except;
`endif
   assign to_s      = (priv_q <= PRIV_S) && medeleg_i[except_wb.ecause[5:0]];
   assign trap_to_s = (op_q == OP_TRAP_S);

   // Sequencing: WB inputs are only looked at in IDLE; exception beats interrupt beats mret beats sret.
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      epc_d       = epc_q;
      cause_d     = cause_q;
      tval_d      = tval_q;
      trap_priv_d = trap_priv_q;
      new_priv_d  = new_priv_q;
      priv_d      = priv_q;
`ifdef TRAP_SEQ_INTR_EN
      is_intr_d   = is_intr_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (take_exc) begin
               epc_d       = except_wb.epc;
               cause_d     = except_wb.ecause;
               tval_d      = except_wb.etval;
               trap_priv_d = priv_q;
               op_d        = to_s ? OP_TRAP_S : OP_TRAP_M;
               new_priv_d  = to_s ? PRIV_S : PRIV_M;
`ifdef TRAP_SEQ_INTR_EN
               is_intr_d   = 1'b0;
`endif
               state_d     = WR_EPC;
`ifdef TRAP_SEQ_INTR_EN
            end else if (take_int) begin
               epc_d       = pc_wb_i;
               cause_d     = int_cause_i;
               tval_d      = '0;
               trap_priv_d = priv_q;
               op_d        = OP_TRAP_M;
               new_priv_d  = PRIV_M;
               is_intr_d   = 1'b1;
               state_d     = WR_EPC;
`endif
            end else if (valid_wb && (mret_wb || sret_wb)) begin
               op_d        = mret_wb ? OP_MRET : OP_SRET;
               trap_priv_d = priv_q;
               state_d     = RET_STATUS;
            end
         end
         WR_EPC:    state_d = WR_CAUSE;
         WR_CAUSE:  state_d = WR_TVAL;
         WR_TVAL:   state_d = WR_STATUS;
         WR_STATUS: state_d = REDIRECT;
         RET_STATUS: begin
            // Capture the return privilege before the mstatus write lands in the CSR file.
            new_priv_d = ret_priv;
            state_d    = REDIRECT;
         end
         REDIRECT: begin
            priv_d  = new_priv_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      case (op_q)
         OP_MRET:   redirect_target = mepc_i;
         OP_SRET:   redirect_target = sepc_i;
         OP_TRAP_S: redirect_target = stvec_i & TVEC_BASE_MASK;
         default:   redirect_target = mtvec_i & TVEC_BASE_MASK;
      endcase
`ifdef TRAP_SEQ_INTR_EN
      if (is_intr_q && (op_q == OP_TRAP_M) && (mtvec_i[1:0] == 2'b01))
         redirect_target = (mtvec_i & TVEC_BASE_MASK) + XLEN'({cause_q[5:0], 2'b00});
`endif
   end

   always_comb begin
      csr_we_o         = 1'b0;
      csr_waddr_o      = '0;
      csr_wdata_o      = '0;
      flush_o          = 1'b0;
      redirect_valid_o = 1'b0;
      redirect_pc_o    = '0;
      unique case (state_q)
         WR_EPC: begin
            csr_we_o    = 1'b1;
            flush_o     = 1'b1;
            csr_waddr_o = trap_csr_addr(trap_to_s, CSR_MEPC, CSR_SEPC);
            csr_wdata_o = epc_q;
         end
         WR_CAUSE: begin
            csr_we_o    = 1'b1;
            csr_waddr_o = trap_csr_addr(trap_to_s, CSR_MCAUSE, CSR_SCAUSE);
            csr_wdata_o = cause_q;
         end
         WR_TVAL: begin
            csr_we_o    = 1'b1;
            csr_waddr_o = trap_csr_addr(trap_to_s, CSR_MTVAL, CSR_STVAL);
            csr_wdata_o = tval_q;
         end
         WR_STATUS: begin
            csr_we_o    = 1'b1;
            csr_waddr_o = CSR_MSTATUS;
            csr_wdata_o = status_img;
         end
         RET_STATUS: begin
            csr_we_o    = 1'b1;
            flush_o     = 1'b1;
            csr_waddr_o = CSR_MSTATUS;
            csr_wdata_o = status_img;
         end
         REDIRECT: begin
            redirect_valid_o = 1'b1;
            redirect_pc_o    = redirect_target;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         op_q        <= OP_TRAP_M;
         epc_q       <= '0;
         cause_q     <= '0;
         tval_q      <= '0;
         trap_priv_q <= '0;
         new_priv_q  <= '0;
         priv_q      <= RESET_PRIV;
`ifdef TRAP_SEQ_INTR_EN
         is_intr_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         epc_q       <= epc_d;
         cause_q     <= cause_d;
         tval_q      <= tval_d;
         trap_priv_q <= trap_priv_d;
         new_priv_q  <= new_priv_d;
         priv_q      <= priv_d;
`ifdef TRAP_SEQ_INTR_EN
         is_intr_q   <= is_intr_d;
`endif
      end
   end

   assign busy_o  = (state_q != IDLE);
   assign stall_o = busy_o;
   assign priv_o  = priv_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Scoreboard bench for trap_sequencer: a transaction-level model predicts every CSR write and redirect.
// Build with TRAP_SEQ_INTR_EN defined to also exercise the interrupt path.
module tb_trap_sequencer;
   import CsrPack::*;

   localparam int XLEN = 64;

   typedef struct {
      bit          valid;
      bit          exc;
      bit          intr;
      bit          mret;
      bit          sret;
      logic [63:0] epc;
      logic [63:0] ecause;
      logic [63:0] etval;
      logic [63:0] int_cause;
      logic [63:0] pc_wb;
      logic [63:0] mstatus;
      logic [63:0] medeleg;
      logic [63:0] mtvec;
      logic [63:0] stvec;
      logic [63:0] mepc;
      logic [63:0] sepc;
   } txn_t;

   typedef struct {
      bit          is_redirect;
      logic [11:0] addr;
      logic [63:0] data;
      bit          flush;
      logic [1:0]  priv;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst;
   logic            valid_wb;
   ExceptPack       except_wb;
   logic            mret_wb;
   logic            sret_wb;
   logic [XLEN-1:0] mstatus_i, medeleg_i, mtvec_i, stvec_i, mepc_i, sepc_i;
   logic            int_req_i;
   logic [XLEN-1:0] int_cause_i, pc_wb_i;
   logic            csr_we_o;
   logic [11:0]     csr_waddr_o;
   logic [XLEN-1:0] csr_wdata_o;
   logic            stall_o, flush_o, redirect_valid_o, busy_o;
   logic [XLEN-1:0] redirect_pc_o;
   logic [1:0]      priv_o;

   int         n_checks = 0;
   int         n_fail   = 0;
   exp_t       sb_q[$];
   exp_t       stage_q[$];
   logic [1:0] model_priv = 2'b11;
   bit         pending_priv = 1'b0;
   logic [1:0] pend_priv_val;
   exp_t       mon_e;

   always #5 clk = ~clk;

   trap_sequencer #(.XLEN(XLEN), .RESET_PRIV(2'b11)) dut (
      .clk              (clk),
      .rst              (rst),
      .valid_wb         (valid_wb),
      .except_wb        (except_wb),
      .mret_wb          (mret_wb),
      .sret_wb          (sret_wb),
      .mstatus_i        (mstatus_i),
      .medeleg_i        (medeleg_i),
      .mtvec_i          (mtvec_i),
      .stvec_i          (stvec_i),
      .mepc_i           (mepc_i),
      .sepc_i           (sepc_i),
`ifdef TRAP_SEQ_INTR_EN
      .int_req_i        (int_req_i),
      .int_cause_i      (int_cause_i),
      .pc_wb_i          (pc_wb_i),
`endif
      .csr_we_o         (csr_we_o),
      .csr_waddr_o      (csr_waddr_o),
      .csr_wdata_o      (csr_wdata_o),
      .stall_o          (stall_o),
      .flush_o          (flush_o),
      .redirect_valid_o (redirect_valid_o),
      .redirect_pc_o    (redirect_pc_o),
      .priv_o           (priv_o),
      .busy_o           (busy_o)
   );

   task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   // Architectural model of one WB event: the list of CSR writes, the redirect and the resulting privilege.
   task automatic modelTxn(input txn_t t, output int cycles);
      logic [63:0] st, pc, epc, cause, tval;
      logic [11:0] base;
      logic [1:0]  newp;
      bit          trap, to_s, vect;
      stage_q.delete();
      cycles = 0;
      trap   = 1'b0;
      to_s   = 1'b0;
      vect   = 1'b0;
      epc    = t.epc;
      cause  = t.ecause;
      tval   = t.etval;
      st     = t.mstatus;
      if (!t.valid) return;
      if (t.exc) begin
         trap = 1'b1;
         to_s = (model_priv <= 2'd1) && t.medeleg[t.ecause[5:0]];
`ifdef TRAP_SEQ_INTR_EN
      end else if (t.intr) begin
         trap  = 1'b1;
         epc   = t.pc_wb;
         cause = t.int_cause;
         tval  = 64'd0;
         vect  = (t.mtvec[1:0] == 2'b01);
`endif
      end
      if (trap) begin
         base = to_s ? 12'h100 : 12'h300;
         stage_q.push_back('{0, base + 12'h41, epc, 1, 0});
         stage_q.push_back('{0, base + 12'h42, cause, 0, 0});
         stage_q.push_back('{0, base + 12'h43, tval, 0, 0});
         if (to_s) begin
            st[5] = st[1];
            st[1] = 1'b0;
            st[8] = model_priv[0];
            newp  = 2'd1;
            pc    = t.stvec & ~64'h3;
         end else begin
            st[7]     = st[3];
            st[3]     = 1'b0;
            st[12:11] = model_priv;
            newp      = 2'd3;
            pc        = t.mtvec & ~64'h3;
            if (vect) pc = pc + 64'(4 * cause[5:0]);
         end
         stage_q.push_back('{0, 12'h300, st, 0, 0});
         stage_q.push_back('{1, 12'h000, pc, 0, newp});
         cycles = 5;
      end else if (t.mret || t.sret) begin
         if (t.mret) begin
            newp      = st[12:11];
            st[3]     = st[7];
            st[7]     = 1'b1;
            st[12:11] = 2'b00;
            pc        = t.mepc;
         end else begin
            newp  = {1'b0, st[8]};
            st[1] = st[5];
            st[5] = 1'b1;
            st[8] = 1'b0;
            pc    = t.sepc;
         end
         stage_q.push_back('{0, 12'h300, st, 1, 0});
         stage_q.push_back('{1, 12'h000, pc, 0, newp});
         cycles = 2;
      end else begin
         return;
      end
      model_priv = newp;
   endtask

   function automatic txn_t blankTxn();
      txn_t t;
      t = '{default: '0};
      t.valid = 1'b1;
      return t;
   endfunction

   function automatic txn_t randomTxn();
      txn_t t;
      t           = blankTxn();
      t.valid     = ($urandom_range(7) != 0);
      t.exc       = ($urandom_range(2) == 0);
      t.intr      = ($urandom_range(2) == 0);
      t.mret      = 1'($urandom_range(1));
      t.sret      = 1'($urandom_range(1));
      t.epc       = {$urandom, $urandom};
      t.ecause    = 64'($urandom_range(63));
      t.etval     = {$urandom, $urandom};
      t.int_cause = {1'b1, 57'd0, 6'($urandom_range(15))};
      t.pc_wb     = {$urandom, $urandom};
      t.mstatus   = {$urandom, $urandom};
      t.medeleg   = {$urandom, $urandom};
      t.mtvec     = {$urandom, $urandom};
      t.stvec     = {$urandom, $urandom};
      t.mepc      = {$urandom, $urandom};
      t.sepc      = {$urandom, $urandom};
      return t;
   endfunction

   task automatic driveCsr(input txn_t t);
      mstatus_i = t.mstatus;
      medeleg_i = t.medeleg;
      mtvec_i   = t.mtvec;
      stvec_i   = t.stvec;
      mepc_i    = t.mepc;
      sepc_i    = t.sepc;
   endtask

   task automatic driveWb(input txn_t t);
      valid_wb         = t.valid;
      except_wb.except = t.exc;
      except_wb.epc    = t.epc;
      except_wb.ecause = t.ecause;
      except_wb.etval  = t.etval;
      mret_wb          = t.mret;
      sret_wb          = t.sret;
      int_req_i        = t.intr;
      int_cause_i      = t.int_cause;
      pc_wb_i          = t.pc_wb;
   endtask

   task automatic driveIdleWb();
      valid_wb  = 1'b0;
      except_wb = '0;
      mret_wb   = 1'b0;
      sret_wb   = 1'b0;
      int_req_i = 1'b0;
   endtask

   // Issue one WB event, hammer the WB inputs with noise while busy, and check how long busy lasted.
   task automatic applyStimulus(input txn_t t);
      int exp_cycles;
      int busy_cycles;
      @(negedge clk);
      driveCsr(t);
      driveWb(t);
      modelTxn(t, exp_cycles);
      while (stage_q.size() > 0) sb_q.push_back(stage_q.pop_front());
      busy_cycles = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (!busy_o) break;
         busy_cycles++;
         driveWb(randomTxn());
      end
      driveIdleWb();
      checkOutput("busy_length", 128'(busy_cycles), 128'(exp_cycles));
   endtask

   // Monitor: every CSR write or redirect the DUT presents must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rst) begin
         pending_priv = 1'b0;
      end else begin
         if (pending_priv) begin
            checkOutput("priv_after_redirect", 128'(priv_o), 128'(pend_priv_val));
            pending_priv = 1'b0;
         end
         if (csr_we_o || redirect_valid_o) begin
            if (sb_q.size() == 0) begin
               checkOutput("unexpected_output", {csr_we_o, redirect_valid_o, csr_waddr_o, redirect_pc_o}, 128'd0);
            end else begin
               mon_e = sb_q.pop_front();
               if (mon_e.is_redirect) begin
                  checkOutput("redirect", {redirect_valid_o, csr_we_o, flush_o, stall_o, redirect_pc_o},
                              {1'b1, 1'b0, 1'b0, 1'b1, mon_e.data});
                  checkOutput("redirect_csr_quiet", {csr_waddr_o, csr_wdata_o}, 128'd0);
                  pending_priv  = 1'b1;
                  pend_priv_val = mon_e.priv;
               end else begin
                  checkOutput("csr_write", {redirect_valid_o, flush_o, stall_o, csr_waddr_o, csr_wdata_o},
                              {1'b0, mon_e.flush, 1'b1, mon_e.addr, mon_e.data});
               end
            end
         end else if (!busy_o) begin
            checkOutput("idle_outputs", {stall_o, flush_o, csr_waddr_o, csr_wdata_o, redirect_pc_o[31:0]}, 128'd0);
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      txn_t t;
      int   dummy;
      rst = 1'b1;
      driveIdleWb();
      int_cause_i = '0;
      pc_wb_i     = '0;
      driveCsr(blankTxn());
      repeat (3) @(negedge clk);
      checkOutput("reset_outputs",
                  {csr_we_o, csr_waddr_o, csr_wdata_o, stall_o, flush_o, redirect_valid_o, busy_o},
                  128'd0);
      checkOutput("reset_priv", 128'(priv_o), 128'd3);
      checkOutput("reset_redirect_pc", 128'(redirect_pc_o), 128'd0);
      rst = 1'b0;

      // MRET with MPP=01, MPIE=1 returns to S at mepc.
      t = blankTxn();
      t.mret    = 1'b1;
      t.mstatus = 64'h880;
      t.mepc    = 64'h8000_0204;
      applyStimulus(t);

      // SRET with SPP=0 drops to U.
      t = blankTxn();
      t.sret = 1'b1;
      t.sepc = 64'h8000_1000;
      applyStimulus(t);

      // ECALL from U, not delegated.
      t = blankTxn();
      t.exc     = 1'b1;
      t.ecause  = 64'd8;
      t.epc     = 64'h8000_0100;
      t.mtvec   = 64'h8000_0001;
      t.mstatus = 64'h8;
      applyStimulus(t);

      // Back to U, then a delegated illegal instruction.
      t = blankTxn();
      t.mret = 1'b1;
      t.mepc = 64'h8000_2000;
      applyStimulus(t);
      t = blankTxn();
      t.exc     = 1'b1;
      t.ecause  = 64'd2;
      t.etval   = 64'h0000_FFFF;
      t.epc     = 64'h8000_2004;
      t.medeleg = 64'h4;
      t.stvec   = 64'h8020_0000;
      t.mstatus = 64'h2;
      applyStimulus(t);

      // Exception and MRET together: the trap wins.
      t = blankTxn();
      t.exc     = 1'b1;
      t.mret    = 1'b1;
      t.ecause  = 64'd5;
      t.epc     = 64'h8000_3000;
      t.mtvec   = 64'h8000_0400;
      t.mepc    = 64'h1234_5678;
      t.mstatus = 64'h1888;
      applyStimulus(t);

`ifdef TRAP_SEQ_INTR_EN
      t = blankTxn();
      t.intr      = 1'b1;
      t.int_cause = 64'h8000_0000_0000_0007;
      t.pc_wb     = 64'h8000_4000;
      t.mtvec     = 64'h8000_0001;
      applyStimulus(t);
`endif

      for (int n = 0; n < 80; n++) applyStimulus(randomTxn());

      // Reset while the trap sequence is in WR_TVAL: status write and redirect never happen.
      t = blankTxn();
      t.exc     = 1'b1;
      t.ecause  = 64'd3;
      t.epc     = 64'h8000_5000;
      t.etval   = 64'hABCD;
      t.mtvec   = 64'h8000_0000;
      t.mstatus = 64'h8;
      @(negedge clk);
      driveCsr(t);
      driveWb(t);
      modelTxn(t, dummy);
      for (int i = 0; i < 3; i++) sb_q.push_back(stage_q.pop_front());
      stage_q.delete();
      @(negedge clk);
      driveIdleWb();
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      checkOutput("abort_quiet", {csr_we_o, stall_o, redirect_valid_o, busy_o}, 128'd0);
      checkOutput("abort_priv", 128'(priv_o), 128'd3);
      #1 rst = 1'b0;
      model_priv = 2'b11;
      repeat (10) @(negedge clk);
      checkOutput("scoreboard_drained", 128'(sb_q.size()), 128'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
